mem_to_axi_bridge: RTL

Memory-request-to-AXI4 initiator: accepts word-wide requests on a req/gnt/rvalid memory port and issues them as single-beat AXI4 transactions on a master port. It is the master-side counterpart of the AXI-to-memory slave path. Typical use: a core or DMA memory port reaching an AXI crossbar. Read and write responses return to the memory port strictly in request order.

---
 rtl/mem_to_axi_bridge.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_to_axi_bridge.sv
// Memory-port (req/gnt/rvalid) to AXI4 master bridge.
// Every granted request becomes one single-beat AXI4 transaction. A 1-bit order
// FIFO records whether each granted request is a read or a write. Responses are
// therefore returned on the memory port strictly in request order.

// Default AXI4 channel and bundle types, sized for the default parameters.
// Integrators with other widths pass their own structs through the type
// parameters. These structs must use the same field names.
package mem_to_axi_bridge_pkg;
  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 64;
  localparam int unsigned AxiIdW   = 1;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [5:0]          atop;
    logic [0:0]          user;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
    logic [0:0]            user;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    logic [1:0]        resp;
    logic [0:0]        user;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [0:0]          user;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic [0:0]          user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module mem_to_axi_bridge #(
  parameter type                  axi_req_t  = mem_to_axi_bridge_pkg::axi_req_t,
  parameter type                  axi_resp_t = mem_to_axi_bridge_pkg::axi_resp_t,
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 64,
  parameter int unsigned          IdWidth    = 1,
  parameter logic [IdWidth-1:0]   AxiId      = '0,
  parameter int unsigned          MaxTrans   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   busy_o,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output axi_req_t               axi_req_o,
  input  axi_resp_t              axi_resp_i
);

  // Every beat carries a full data word.
  localparam logic [2:0] AxiSize  = 3'($clog2(DataWidth / 8));
  localparam logic [1:0] BurstIncr = 2'b01;

  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef enum logic [1:0] {
    WrIdle   = 2'd0,
    WrAwDone = 2'd1,
    WrWDone  = 2'd2
  } wr_state_e;

  // Order FIFO state: one bit per outstanding transaction, 1 = write.
  logic [MaxTrans-1:0] order_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     cnt_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                head_is_write;
  logic                push;
  logic                pop;

  wr_state_e wr_state_q;

  logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wr_gnt;
  logic read_req, write_req;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come only from registered state, so a pop in the same cycle
  // cannot open a slot for a new grant.
  assign fifo_full     = (cnt_q == CntW'(MaxTrans));
  assign fifo_empty    = (cnt_q == '0);
  assign head_is_write = order_q[rd_ptr_q];

  assign read_req  = mem_req_i & ~mem_we_i;
  assign write_req = mem_req_i &  mem_we_i;

  // Write channel valids depend on which half of the write is still pending.
  // A partially issued write always completes, so the full check only gates
  // the first issue.
  always_comb begin
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        aw_valid = write_req & ~fifo_full;
        w_valid  = write_req & ~fifo_full;
      end
      WrAwDone: w_valid  = 1'b1;
      WrWDone:  aw_valid = 1'b1;
      default: begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
      end
    endcase
  end

  // Reads wait while a write is half issued. That request is still held
  // on the memory port.
  assign ar_valid = read_req & ~fifo_full & (wr_state_q == WrIdle);

  assign aw_hs = aw_valid & axi_resp_i.aw_ready;
  assign w_hs  = w_valid  & axi_resp_i.w_ready;
  assign ar_hs = ar_valid & axi_resp_i.ar_ready;

  // A write is granted when its last outstanding channel handshakes.
  always_comb begin
    wr_gnt = 1'b0;
    unique case (wr_state_q)
      WrIdle:   wr_gnt = aw_hs & w_hs;
      WrAwDone: wr_gnt = w_hs;
      WrWDone:  wr_gnt = aw_hs;
      default:  wr_gnt = 1'b0;
    endcase
  end

  assign mem_gnt_o = ar_hs | wr_gnt;
  assign push      = mem_gnt_o;

  // Only the response matching the oldest outstanding request is accepted.
  // The other response is held off until it reaches the head.
  assign r_ready = ~fifo_empty & ~head_is_write;
  assign b_ready = ~fifo_empty &  head_is_write;
  assign r_hs    = axi_resp_i.r_valid & r_ready;
  assign b_hs    = axi_resp_i.b_valid & b_ready;
  assign pop     = r_hs | b_hs;

  assign mem_rvalid_o = pop;
  assign mem_rdata_o  = r_hs ? axi_resp_i.r.data : '0;
  assign mem_err_o    = (r_hs & axi_resp_i.r.resp[1]) | (b_hs & axi_resp_i.b.resp[1]);

  assign busy_o = ~fifo_empty | (wr_state_q != WrIdle);

  // Write FSM: track which half of a write has already handshaken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WrIdle;
    end else begin
      unique case (wr_state_q)
        WrIdle: begin
          if (aw_hs && !w_hs) begin
            wr_state_q <= WrAwDone;
          end else if (w_hs && !aw_hs) begin
            wr_state_q <= WrWDone;
          end
        end
        WrAwDone: if (w_hs)  wr_state_q <= WrIdle;
        WrWDone:  if (aw_hs) wr_state_q <= WrIdle;
        default:  wr_state_q <= WrIdle;
      endcase
    end
  end

  // Order FIFO: push the request kind on grant, pop on each returned response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      order_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        order_q[wr_ptr_q] <= mem_we_i;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Drive the AXI request bundle. Every field that is not listed here stays 0.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AxiId;
    axi_req_o.aw.addr  = mem_addr_i;
    axi_req_o.aw.len   = 8'd0;
    axi_req_o.aw.size  = AxiSize;
    axi_req_o.aw.burst = BurstIncr;
    axi_req_o.aw_valid = aw_valid;
    axi_req_o.w.data   = mem_wdata_i;
    axi_req_o.w.strb   = mem_strb_i;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.b_ready  = b_ready;
    axi_req_o.ar.id    = AxiId;
    axi_req_o.ar.addr  = mem_addr_i;
    axi_req_o.ar.len   = 8'd0;
    axi_req_o.ar.size  = AxiSize;
    axi_req_o.ar.burst = BurstIncr;
    axi_req_o.ar_valid = ar_valid;
    axi_req_o.r_ready  = r_ready;
  end

  // Response fields the bridge has no use for. Only single beats with one
  // fixed ID are ever in flight.
  logic unused_resp;
  assign unused_resp = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                         axi_resp_i.r.resp[0], axi_resp_i.b.id, axi_resp_i.b.user,
                         axi_resp_i.b.resp[0]};

endmodule
